// File: rtl/col_nos_pkg.sv
// Shared definitions for the col_nos column-index memory and its loader.
// Element width, loader FSM states and the line-width helper.
package col_nos_pkg;

    localparam int COL_NOS_ELEM_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } col_nos_loader_state_t;

    function automatic int col_nos_line_width(input int modules, input int elems);
        return modules * elems * COL_NOS_ELEM_W;
    endfunction

endpackage

// File: rtl/col_nos_line_packer.sv
// Assembles accepted column indices into one col_nos line.
// Slot k of the line receives the k-th accepted element; element 0 at the LSB.
module col_nos_line_packer
    import col_nos_pkg::*;
#(
    parameter int line_elems = 80
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 accept,
    input  logic [COL_NOS_ELEM_W-1:0]            elem,
    output logic [line_elems*COL_NOS_ELEM_W-1:0] line,
    output logic                                 last
);

    localparam int CW = (line_elems > 1) ? $clog2(line_elems) : 1;

    logic [CW-1:0] count;

    assign last = (count == CW'(line_elems - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            line  <= '0;
        end else if (accept) begin
            line[int'(count)*COL_NOS_ELEM_W +: COL_NOS_ELEM_W] <= elem;
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/col_nos_loader.sv
// Streams column indices into full col_nos lines and writes them to
// consecutive addresses from a programmed base.
module col_nos_loader
    import col_nos_pkg::*;
#(
    parameter int  no_of_elements_on_col_nos   = 20,
    parameter int  no_of_row_by_vector_modules = 4,
    localparam int N = no_of_elements_on_col_nos * no_of_row_by_vector_modules,
    localparam int W = col_nos_line_width(no_of_row_by_vector_modules,
                                          no_of_elements_on_col_nos)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   base_address,
    input  logic [31:0]   line_count,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          col_nos_write_enable,
    output logic [31:0]   col_nos_write_address,
    output logic [W-1:0]  col_nos_write_data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   lines_written
);

    col_nos_loader_state_t state, state_next;

    logic [31:0] base_reg;
    logic [31:0] count_reg;
    logic        accept;
    logic        last;
    logic        start_ok;

    assign start_ok = (state == IDLE) && start;
    assign accept   = in_valid && in_ready;

    col_nos_line_packer #(
        .line_elems(N)
    ) u_packer (
        .clk   (clk),
        .reset (reset),
        .accept(accept),
        .elem  (in_data),
        .line  (col_nos_write_data),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            base_reg      <= '0;
            count_reg     <= '0;
            lines_written <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                base_reg      <= base_address;
                count_reg     <= line_count;
                lines_written <= '0;
            end else if (state == WRITE) begin
                lines_written <= lines_written + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = (line_count == '0) ? DONE : FILL;
            FILL:  if (accept && last) state_next = WRITE;
            WRITE: state_next = (lines_written + 32'd1 == count_reg) ? DONE : FILL;
            DONE:  state_next = IDLE;
        endcase
    end

    // The line index is the running count of lines written in this load.
    assign col_nos_write_address = base_reg + lines_written;
    assign col_nos_write_enable  = (state == WRITE);
    assign in_ready              = (state == FILL);
    assign busy                  = (state == FILL) || (state == WRITE);
    assign done                  = (state == DONE);

endmodule

// File: tb/tb_col_nos_loader.sv
// Randomized directed bench for col_nos_loader with a queue-based line model.
module tb_col_nos_loader;
    import col_nos_pkg::*;

    localparam int N = 80;
    localparam int W = col_nos_line_width(4, 20);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_address = '0;
    logic [31:0]   line_count = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          col_nos_write_enable;
    logic [31:0]   col_nos_write_address;
    logic [W-1:0]  col_nos_write_data;
    logic          busy;
    logic          done;
    logic [31:0]   lines_written;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ready_bad = 0;
    int wr_cyc = 0;
    int done_cyc = 0;
    int first_acc = 0;

    logic [31:0]  wr_addr[$];
    logic [W-1:0] wr_data[$];
    logic [31:0]  src[$];
    logic [31:0]  ref_elems[$];

    col_nos_loader dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .base_address         (base_address),
        .line_count           (line_count),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_data              (in_data),
        .col_nos_write_enable (col_nos_write_enable),
        .col_nos_write_address(col_nos_write_address),
        .col_nos_write_data   (col_nos_write_data),
        .busy                 (busy),
        .done                 (done),
        .lines_written        (lines_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (col_nos_write_enable) begin
            wr_addr.push_back(col_nos_write_address);
            wr_data.push_back(col_nos_write_data);
            wr_cyc = cyc;
            if (in_ready) ready_bad++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, col_nos_write_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, col_nos_write_address, 0);
        chk({tag, "_data"}, |col_nos_write_data, 0);
        chk({tag, "_lines"}, lines_written, 0);
    endtask

    task automatic start_load(input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        start = 1'b1;
        base_address = b;
        line_count = c;
        @(negedge clk);
        start = 1'b0;
        base_address = $urandom;
        line_count = $urandom;
        chk("busy_after_start", busy, c != 0);
        chk("ready_after_start", in_ready, c != 0);
        chk("done_after_start", done, c == 0);
    endtask

    task automatic prep_ramp(input int n, input logic [31:0] off);
        src.delete();
        ref_elems.delete();
        for (int i = 0; i < n; i++) begin
            src.push_back(off + 32'(i));
            ref_elems.push_back(off + 32'(i));
        end
    endtask

    task automatic prep_rand(input int n);
        logic [31:0] v;
        src.delete();
        ref_elems.delete();
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            src.push_back(v);
            ref_elems.push_back(v);
        end
    endtask

    // Offer src elements with random in_valid gaps; optionally pulse a
    // competing start on iteration inj_at.
    task automatic feed(input int gap, input int inj_at, input int budget);
        int n = 0;
        int it = 0;
        while (src.size() > 0 && it < budget) begin
            @(negedge clk);
            it++;
            if (it == inj_at) begin
                start = 1'b1;
                base_address = 32'h999;
                line_count = 32'd7;
            end else begin
                start = 1'b0;
            end
            in_valid = ($urandom_range(99) >= gap);
            in_data = src[0];
            if (in_valid && in_ready) begin
                if (n == 0) first_acc = cyc;
                n++;
                void'(src.pop_front());
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        chk("feed_drained", src.size(), 0);
    endtask

    task automatic wait_done(input int budget, input bit inj);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", done, 1);
        if (inj && done) begin
            start = 1'b1;
            base_address = 32'h555;
            line_count = 32'd4;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic check_writes(input logic [31:0] base, input int lines, input int w0);
        logic [W-1:0] d;
        logic [31:0]  a;
        chk("wr_count", wr_addr.size() - w0, lines);
        for (int i = 0; i < lines && w0 + i < wr_addr.size(); i++) begin
            a = base + 32'(i);
            chk($sformatf("wr%0d_addr", i), wr_addr[w0 + i], a);
            d = wr_data[w0 + i];
            for (int k = 0; k < N; k++)
                chk($sformatf("wr%0d_slot%0d", i, k), d[k*32 +: 32], ref_elems[i*N + k]);
        end
    endtask

    initial begin
        int w0;
        int d0;
        int rb0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // Single line, back-to-back
        w0 = wr_addr.size();
        d0 = done_cnt;
        start_load(32'h10, 32'd1);
        prep_ramp(N, 32'd0);
        feed(0, 0, 2000);
        wait_done(200, 1'b0);
        @(negedge clk);
        check_writes(32'h10, 1, w0);
        chk("single_strobe_latency", wr_cyc - first_acc, N);
        chk("single_done_after_write", done_cyc - wr_cyc, 1);
        chk("single_done_pulses", done_cnt - d0, 1);
        chk("single_lines", lines_written, 1);
        chk("single_busy_idle", busy, 0);

        // Multi-line with gaps and address wrap
        w0 = wr_addr.size();
        d0 = done_cnt;
        rb0 = ready_bad;
        start_load(32'hFFFF_FFFE, 32'd3);
        prep_ramp(3 * N, 32'd1000);
        feed(30, 0, 3000);
        wait_done(300, 1'b0);
        @(negedge clk);
        check_writes(32'hFFFF_FFFE, 3, w0);
        chk("multi_ready_low_on_write", ready_bad - rb0, 0);
        chk("multi_lines", lines_written, 3);
        chk("multi_done_pulses", done_cnt - d0, 1);

        // Zero count
        w0 = wr_addr.size();
        d0 = done_cnt;
        start_load(32'h40, 32'd0);
        @(negedge clk);
        chk("zero_done_one_cycle", done, 0);
        repeat (5) @(negedge clk);
        chk("zero_no_write", wr_addr.size() - w0, 0);
        chk("zero_done_pulses", done_cnt - d0, 1);
        chk("zero_lines", lines_written, 0);
        chk("zero_busy", busy, 0);

        // Abort by reset mid-line
        w0 = wr_addr.size();
        start_load(32'h77, 32'd2);
        prep_rand(40);
        feed(25, 0, 1000);
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("abort");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_addr.size() - w0, 0);
        chk("abort_ready_idle", in_ready, 0);

        // Fresh load after abort
        w0 = wr_addr.size();
        start_load(32'd5, 32'd1);
        prep_rand(N);
        feed(15, 0, 2000);
        wait_done(200, 1'b0);
        @(negedge clk);
        check_writes(32'd5, 1, w0);
        chk("fresh_lines", lines_written, 1);

        // Starts during FILL and DONE are ignored
        w0 = wr_addr.size();
        d0 = done_cnt;
        start_load(32'h200, 32'd2);
        prep_rand(2 * N);
        feed(20, 30, 3000);
        wait_done(300, 1'b1);
        repeat (6) @(negedge clk);
        check_writes(32'h200, 2, w0);
        chk("ignored_lines_kept", lines_written, 2);
        chk("ignored_busy", busy, 0);
        chk("ignored_ready", in_ready, 0);
        chk("ignored_done_pulses", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
